// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
//
// Parameterised Johnson (twisted-ring) counter with 2*WIDTH phases. It supports
// bidirectional stepping, synchronous clear and phase load, and it corrects
// itself out of illegal states. The binary phase index is decoded
// combinationally from the state register.
//
// Ports
//   clk        : system clock; all state updates happen on the rising edge
//   reset_n    : asynchronous active-low reset (q=0, wrap=0, err=0)
//   en         : count enable; one step per enabled cycle
//   dir        : 1 = up (shift left), 0 = down (shift right)
//   clr        : synchronous clear to phase 0 (highest priority)
//   load       : synchronous load of the phase given on load_phase
//   load_phase : phase index to load, 0..2*WIDTH-1
//   q          : Johnson state register
//   phase      : binary phase index decoded from q (reads 0 while q is illegal)
//   wrap       : registered one-cycle pulse after an en step crosses the ring end
//   err        : registered one-cycle pulse on an illegal-state correction or a
//                bad load
// -----------------------------------------------------------------------------
module johnson_counter_param #(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam int NPH = 2 * WIDTH;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             legal;
    logic             wrap_next;
    logic             err_next;

    // Phase k encodes as k low ones for k <= WIDTH. Past that point the ones
    // are cleared from the bottom, one per phase.
    function automatic logic [WIDTH-1:0] encode(input logic [PW-1:0] k);
        logic [WIDTH-1:0] v;
        int ki;
        ki = int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = (ki <= WIDTH) ? (i < ki) : (i >= ki - WIDTH);
        end
        return v;
    endfunction

    // A valid Johnson word has at most one boundary between its ones and its
    // zeros.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int t;
        t = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) t++;
        end
        return (t <= 1);
    endfunction

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Decode: the first half of the ring has MSB=0 and phase=popcount. The
    // second half has MSB=1 and the ones drain away, so phase=2W-popcount.
    always_comb begin
        int pop;
        legal = is_legal(q_r);
        pop   = popcount(q_r);
        phase = '0;
        if (legal) begin
            phase = q_r[WIDTH-1] ? PW'(NPH - pop) : PW'(pop);
        end
    end

    // Next-state priority: clr > load > correction > en step > hold.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        q_next    = q_r;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            if (int'(load_phase) < NPH) begin
                q_next = encode(load_phase);
            end else begin
                err_next = 1'b1;
            end
        end else if (!legal) begin
            q_next   = '0;
            err_next = 1'b1;
        end else if (en) begin
            if (dir) begin
                q_next    = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
                wrap_next = (phase == PW'(NPH - 1));
            end else begin
                q_next    = {~q_r[0], q_r[WIDTH-1:1]};
                wrap_next = (phase == '0);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q_r  <= q_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

    assign q = q_r;

endmodule
